// File: rtl/axis_encoder_8b10b.sv
// 8b/10b encoder (IEEE 802.3 clause 36 tables) with an AXI-Stream byte input and K28.5 idle fill.
// Optional: define ENC8B10B_KCHECK_EN to flag illegal K requests on kerr and replace them with IDLE_CHAR.
module axis_encoder_8b10b #(
  parameter logic [7:0] IDLE_CHAR = 8'hBC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tuser,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [9:0] dout,
  output logic       dout_valid,
  output logic       disp,
  output logic       kerr
);

  // 5b/6b codes in their RD- form (abcdei); the RD+ form is derived by complementing.
  function automatic logic [5:0] enc6_base(input logic [4:0] x);
    case (x)
      5'd0:  enc6_base = 6'b100111;  5'd1:  enc6_base = 6'b011101;
      5'd2:  enc6_base = 6'b101101;  5'd3:  enc6_base = 6'b110001;
      5'd4:  enc6_base = 6'b110101;  5'd5:  enc6_base = 6'b101001;
      5'd6:  enc6_base = 6'b011001;  5'd7:  enc6_base = 6'b111000;
      5'd8:  enc6_base = 6'b111001;  5'd9:  enc6_base = 6'b100101;
      5'd10: enc6_base = 6'b010101;  5'd11: enc6_base = 6'b110100;
      5'd12: enc6_base = 6'b001101;  5'd13: enc6_base = 6'b101100;
      5'd14: enc6_base = 6'b011100;  5'd15: enc6_base = 6'b010111;
      5'd16: enc6_base = 6'b011011;  5'd17: enc6_base = 6'b100011;
      5'd18: enc6_base = 6'b010011;  5'd19: enc6_base = 6'b110010;
      5'd20: enc6_base = 6'b001011;  5'd21: enc6_base = 6'b101010;
      5'd22: enc6_base = 6'b011010;  5'd23: enc6_base = 6'b111010;
      5'd24: enc6_base = 6'b110011;  5'd25: enc6_base = 6'b100110;
      5'd26: enc6_base = 6'b010110;  5'd27: enc6_base = 6'b110110;
      5'd28: enc6_base = 6'b001110;  5'd29: enc6_base = 6'b101110;
      5'd30: enc6_base = 6'b011110;  default: enc6_base = 6'b101011;
    endcase
  endfunction

  // 3b/4b codes in their RD- form (fghj); alt selects the A7 code for y=7.
  function automatic logic [3:0] enc4_base(input logic [2:0] y, input logic alt);
    case (y)
      3'd0: enc4_base = 4'b1011;
      3'd1: enc4_base = 4'b1001;
      3'd2: enc4_base = 4'b0101;
      3'd3: enc4_base = 4'b1100;
      3'd4: enc4_base = 4'b1101;
      3'd5: enc4_base = 4'b1010;
      3'd6: enc4_base = 4'b0110;
      default: enc4_base = alt ? 4'b0111 : 4'b1110;
    endcase
  endfunction

`ifdef ENC8B10B_KCHECK_EN
  function automatic logic k_legal(input logic [7:0] b);
    k_legal = (b[4:0] == 5'd28) ||
              ((b[7:5] == 3'd7) && ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
                                    (b[4:0] == 5'd29) || (b[4:0] == 5'd30)));
  endfunction
`endif

  logic [9:0] dout_q, dout_d;
  logic       disp_q, disp_d;
  logic       dout_valid_q, kerr_q, kerr_d;
  logic [7:0] sel_byte;
  logic       sel_k, rd6, alt7;
  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] c6;
  logic [3:0] c4;

  assign s_axis_tready = en & ~rst;

  always_comb begin
    sel_byte = s_axis_tdata;
    sel_k    = s_axis_tuser;
    kerr_d   = 1'b0;
    if (!s_axis_tvalid) begin
      sel_byte = IDLE_CHAR;
      sel_k    = 1'b1;
    end
`ifdef ENC8B10B_KCHECK_EN
    if (sel_k && !k_legal(sel_byte)) begin
      kerr_d   = 1'b1;
      sel_byte = IDLE_CHAR;
    end
`endif
    x = sel_byte[4:0];
    y = sel_byte[7:5];

    c6 = (sel_k && (x == 5'd28)) ? 6'b001111 : enc6_base(x);
    // Unbalanced codes and the RD-specific 111000 flip to their complement at RD+.
    if (disp_q && (($countones(c6) != 3) || (c6 == 6'b111000))) c6 = ~c6;
    rd6 = ($countones(c6) != 3) ? ~disp_q : disp_q;

    alt7 = sel_k || (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)))
                 || ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    c4 = enc4_base(y, alt7);
    // K characters take the inverted balanced 4b codes at RD-, which forms the comma.
    if (rd6 && (($countones(c4) != 2) || (c4 == 4'b1100))) c4 = ~c4;
    else if (sel_k && !rd6 && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6))) c4 = ~c4;

    dout_d = {c6, c4};
    disp_d = ($countones(c4) != 2) ? ~rd6 : rd6;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= 10'h000;
      disp_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      kerr_q       <= 1'b0;
    end else begin
      dout_valid_q <= en;
      kerr_q       <= en & kerr_d;
      if (en) begin
        dout_q <= dout_d;
        disp_q <= disp_d;
      end
    end
  end

  assign dout       = dout_q;
  assign disp       = disp_q;
  assign dout_valid = dout_valid_q;
  assign kerr       = kerr_q;

endmodule
